// File: rtl/apb2_pwm_led.sv
// ============================================================================
// apb2_pwm_led
// ----------------------------------------------------------------------------
// APB2 slave that drives one LED through an 8-bit PWM with an optional
// slow blink gate.
//
// Register map (byte address, decoded on paddr[7:2]):
//   0x00 CTRL       [2:0]  bit0 EN, bit1 BLINK_EN, bit2 INV
//   0x04 PRESCALE   [15:0] prescaler reload, tick when count == PRESCALE
//   0x08 DUTY       [7:0]  PWM compare, pwm = (pwm_cnt < DUTY)
//   0x0C BLINK_HALF [15:0] PWM periods per blink half-phase, minus one
//   0x10 STATUS     (RO)   bit0 led_o, bit1 blink phase, [15:8] PWM counter
//
// Ports:
//   pclk     in   single clock, shared with the APB master
//   prst     in   synchronous active-high reset
//   psel, penable, pwrite, paddr[7:0], pwdata[31:0], pstrb[3:0],
//   pprot[2:0] (ignored)                       APB2 request
//   prdata[31:0], pready, pslverr              APB2 response
//   led_o    out  registered LED drive
//
// Parameters:
//   RST_PRESCALE  PRESCALE value after reset
//   RST_DUTY      DUTY value after reset
//
// Build option:
//   APB2_PWM_LED_PSTRB_EN  when defined, writes honour pstrb per byte lane;
//                          otherwise pstrb is ignored and all implemented
//                          bits are written.
// ============================================================================
module apb2_pwm_led #(
  parameter logic [15:0] RST_PRESCALE = 16'd269,
  parameter logic [7:0]  RST_DUTY     = 8'd128
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  input  logic [2:0]  pprot,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        led_o
);

  // Register indices on paddr[4:2]; anything at or above 0x14 is rejected.
  localparam logic [2:0]  IDX_CTRL       = 3'd0;
  localparam logic [2:0]  IDX_PRESCALE   = 3'd1;
  localparam logic [2:0]  IDX_DUTY       = 3'd2;
  localparam logic [2:0]  IDX_BLINK_HALF = 3'd3;
  localparam logic [2:0]  IDX_STATUS     = 3'd4;
  localparam logic [7:0]  ADDR_LIMIT     = 8'h14;
  localparam logic [15:0] RST_BLINK_HALF = 16'd49;

`ifdef APB2_PWM_LED_PSTRB_EN
  // Byte-lane merge for the 16-bit registers: lanes with strobe 0 keep old bits.
  function automatic logic [15:0] lane_merge16(input logic [15:0] old_v,
                                               input logic [15:0] new_v,
                                               input logic [1:0]  strb);
    lane_merge16 = {(strb[1] ? new_v[15:8] : old_v[15:8]),
                    (strb[0] ? new_v[7:0]  : old_v[7:0])};
  endfunction
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]  ctrl_q,       ctrl_d;
  logic [15:0] prescale_q,   prescale_d;
  logic [7:0]  duty_q,       duty_d;
  logic [15:0] blink_half_q, blink_half_d;
  logic [15:0] pre_cnt_q,    pre_cnt_d;
  logic [7:0]  pwm_cnt_q,    pwm_cnt_d;
  logic [15:0] blink_cnt_q,  blink_cnt_d;
  logic        phase_q,      phase_d;
  logic        led_q,        led_d;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic        addr_ok_s;
  logic        bad_s;
  logic        acc_s;
  logic        wr_en_s;
  logic [2:0]  reg_idx_s;
  logic        wr_ctrl_s;
  logic        wr_prescale_s;
  logic        wr_duty_s;
  logic        wr_blink_half_s;
  logic [2:0]  ctrl_wdata_s;
  logic [15:0] prescale_wdata_s;
  logic [7:0]  duty_wdata_s;
  logic [15:0] blink_half_wdata_s;
  logic        en_s;
  logic        blink_en_s;
  logic        inv_s;
  logic        tick_s;
  logic        wrap_s;
  logic        pwm_s;
  logic        unused_s;

  // Protection bits, upper data bits and (when unused) strobes carry no meaning.
  assign unused_s = ^{pprot, pwdata[31:16], pstrb};

  assign en_s       = ctrl_q[0];
  assign blink_en_s = ctrl_q[1];
  assign inv_s      = ctrl_q[2];

  // Zero wait states: the slave is always ready, in reset and out of it.
  assign pready = 1'b1;
  assign led_o  = led_q;

  // Address decode and error classification of the current APB request.
  always_comb begin
    reg_idx_s = paddr[4:2];
    acc_s     = psel & penable;
    addr_ok_s = (paddr[1:0] == 2'b00) && (paddr < ADDR_LIMIT);
    if (!addr_ok_s) begin
      bad_s = 1'b1;
    end else if (pwrite && (reg_idx_s == IDX_STATUS)) begin
      bad_s = 1'b1;
    end else begin
      bad_s = 1'b0;
    end
    pslverr = acc_s & bad_s;
    wr_en_s = acc_s & pwrite & ~bad_s;
  end

  // Per-register write strobes; errored accesses never reach a register.
  always_comb begin
    wr_ctrl_s       = wr_en_s & (reg_idx_s == IDX_CTRL);
    wr_prescale_s   = wr_en_s & (reg_idx_s == IDX_PRESCALE);
    wr_duty_s       = wr_en_s & (reg_idx_s == IDX_DUTY);
    wr_blink_half_s = wr_en_s & (reg_idx_s == IDX_BLINK_HALF);
  end

  // Write data per register, with optional byte-lane masking.
  always_comb begin
`ifdef APB2_PWM_LED_PSTRB_EN
    ctrl_wdata_s       = pstrb[0] ? pwdata[2:0] : ctrl_q;
    prescale_wdata_s   = lane_merge16(prescale_q, pwdata[15:0], pstrb[1:0]);
    duty_wdata_s       = pstrb[0] ? pwdata[7:0] : duty_q;
    blink_half_wdata_s = lane_merge16(blink_half_q, pwdata[15:0], pstrb[1:0]);
`else
    ctrl_wdata_s       = pwdata[2:0];
    prescale_wdata_s   = pwdata[15:0];
    duty_wdata_s       = pwdata[7:0];
    blink_half_wdata_s = pwdata[15:0];
`endif
  end

  // Register file next-state.
  always_comb begin
    ctrl_d       = ctrl_q;
    prescale_d   = prescale_q;
    duty_d       = duty_q;
    blink_half_d = blink_half_q;
    if (wr_ctrl_s) begin
      ctrl_d = ctrl_wdata_s;
    end else begin
      ctrl_d = ctrl_q;
    end
    if (wr_prescale_s) begin
      prescale_d = prescale_wdata_s;
    end else begin
      prescale_d = prescale_q;
    end
    if (wr_duty_s) begin
      duty_d = duty_wdata_s;
    end else begin
      duty_d = duty_q;
    end
    if (wr_blink_half_s) begin
      blink_half_d = blink_half_wdata_s;
    end else begin
      blink_half_d = blink_half_q;
    end
  end

  // Prescaler tick, PWM wrap and PWM compare, all from registered state.
  // The tick is gated by EN so a zero PRESCALE does not tick while disabled.
  always_comb begin
    tick_s = en_s & (pre_cnt_q == prescale_q);
    wrap_s = tick_s & (pwm_cnt_q == 8'd255);
    pwm_s  = (pwm_cnt_q < duty_q);
  end

  // Prescaler: 0..PRESCALE, restarted whenever PRESCALE is rewritten so a
  // smaller reload never leaves the count stranded above it.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (!en_s) begin
      pre_cnt_d = 16'd0;
    end else if (wr_prescale_s) begin
      pre_cnt_d = 16'd0;
    end else if (tick_s) begin
      pre_cnt_d = 16'd0;
    end else begin
      pre_cnt_d = pre_cnt_q + 16'd1;
    end
  end

  // PWM counter: free-running 8-bit, one step per tick, natural 255->0 wrap.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    if (!en_s) begin
      pwm_cnt_d = 8'd0;
    end else if (tick_s) begin
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end else begin
      pwm_cnt_d = pwm_cnt_q;
    end
  end

  // Blink counter and phase. The >= compare lets a BLINK_HALF lowered below
  // the running count take effect on the next wrap instead of after 64k wraps.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!en_s) begin
      blink_cnt_d = 16'd0;
      phase_d     = 1'b0;
    end else if (wrap_s) begin
      if (blink_cnt_q >= blink_half_q) begin
        blink_cnt_d = 16'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
        phase_d     = phase_q;
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
    end
  end

  // LED drive: blink gate only passes the PWM while phase is 1.
  always_comb begin
    led_d = inv_s ^ (en_s & pwm_s & (~blink_en_s | phase_q));
  end

  // Read mux: combinational during any read cycle, zero otherwise.
  always_comb begin
    prdata = 32'd0;
    if (psel && !pwrite && addr_ok_s) begin
      case (reg_idx_s)
        IDX_CTRL:       prdata = {29'd0, ctrl_q};
        IDX_PRESCALE:   prdata = {16'd0, prescale_q};
        IDX_DUTY:       prdata = {24'd0, duty_q};
        IDX_BLINK_HALF: prdata = {16'd0, blink_half_q};
        IDX_STATUS:     prdata = {16'd0, pwm_cnt_q, 6'd0, phase_q, led_q};
        default:        prdata = 32'd0;
      endcase
    end else begin
      prdata = 32'd0;
    end
  end

  // State registers; reset wins over a coincident APB write.
  always_ff @(posedge pclk) begin
    if (prst) begin
      ctrl_q       <= 3'd0;
      prescale_q   <= RST_PRESCALE;
      duty_q       <= RST_DUTY;
      blink_half_q <= RST_BLINK_HALF;
      pre_cnt_q    <= 16'd0;
      pwm_cnt_q    <= 8'd0;
      blink_cnt_q  <= 16'd0;
      phase_q      <= 1'b0;
      led_q        <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      prescale_q   <= prescale_d;
      duty_q       <= duty_d;
      blink_half_q <= blink_half_d;
      pre_cnt_q    <= pre_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      led_q        <= led_d;
    end
  end

endmodule

// File: tb/tb_apb2_pwm_led.sv
// Scoreboard bench for apb2_pwm_led: stimulus queues expected APB responses
// and LED/handshake probes; a negedge monitor pops and compares them.
module tb_apb2_pwm_led;

  logic        pclk = 1'b0;
  logic        prst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        led_o;

  int checks = 0;
  int errors = 0;

  // APB expectations
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_mask_q[$];
  logic        exp_err_q[$];
  string       exp_name_q[$];
  // Probe expectations: {pready, pslverr, led_o}
  logic [2:0]  probe_q[$];
  string       probe_name_q[$];
  logic        probe = 1'b0;

`ifdef APB2_PWM_LED_PSTRB_EN
  localparam logic [31:0] STRB_DUTY_EXP = 32'h0000_0080;
`else
  localparam logic [31:0] STRB_DUTY_EXP = 32'h0000_00FF;
`endif

  apb2_pwm_led dut (
    .pclk    (pclk),
    .prst    (prst),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .pprot   (pprot),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .led_o   (led_o)
  );

  always #5 pclk = ~pclk;

  // Monitor: compares every access phase and every probed cycle.
  always @(negedge pclk) begin
    if (psel && penable) begin
      checks++;
      if (exp_data_q.size() == 0) begin
        errors++;
        $display("FAIL apb_unexpected: access at paddr=%h with nothing queued", paddr);
      end else begin
        logic [31:0] d, m;
        logic        e;
        string       nm;
        d  = exp_data_q.pop_front();
        m  = exp_mask_q.pop_front();
        e  = exp_err_q.pop_front();
        nm = exp_name_q.pop_front();
        if (!((pready === 1'b1) && (pslverr === e) && ((prdata & m) === (d & m)))) begin
          errors++;
          $display("FAIL %s: got prdata=%h pready=%b pslverr=%b, expected prdata=%h (mask %h) pready=1 pslverr=%b",
                   nm, prdata, pready, pslverr, d, m, e);
        end
      end
    end
    if (probe) begin
      checks++;
      if (probe_q.size() == 0) begin
        errors++;
        $display("FAIL probe_unexpected: probe with nothing queued");
      end else begin
        logic [2:0] x;
        string      nm;
        x  = probe_q.pop_front();
        nm = probe_name_q.pop_front();
        if ({pready, pslverr, led_o} !== x) begin
          errors++;
          $display("FAIL %s: got pready/pslverr/led_o=%b%b%b, expected %b",
                   nm, pready, pslverr, led_o, x);
        end
      end
    end
  end

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic e, input string nm);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    exp_data_q.push_back(32'd0);
    exp_mask_q.push_back(32'hFFFF_FFFF);
    exp_err_q.push_back(e);
    exp_name_q.push_back(nm);
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, input logic [31:0] d, input logic [31:0] m,
                        input logic e, input string nm);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; pwdata = 32'd0; pstrb = 4'd0;
    @(posedge pclk); #1;
    exp_data_q.push_back(d);
    exp_mask_q.push_back(m);
    exp_err_q.push_back(e);
    exp_name_q.push_back(nm);
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Probe the current cycle: {pready, pslverr, led_o}.
  task automatic do_probe(input logic [2:0] x, input string nm);
    probe_q.push_back(x);
    probe_name_q.push_back(nm);
    probe = 1'b1;
    @(negedge pclk); #1;
    probe = 1'b0;
  endtask

  initial begin
    // Reset for two edges with a concurrent CTRL=1 write that must lose.
    prst = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h00; pwdata = 32'd1; pstrb = 4'hF; pprot = 3'd0;
    @(posedge pclk); #1;
    exp_data_q.push_back(32'd0);
    exp_mask_q.push_back(32'hFFFF_FFFF);
    exp_err_q.push_back(1'b0);
    exp_name_q.push_back("rst_ctrl_write");
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; prst = 1'b0;
    do_probe(3'b100, "rst_led");
    apb_rd(8'h00, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "rst_ctrl");
    apb_rd(8'h04, 32'h0000_010D, 32'hFFFF_FFFF, 1'b0, "rst_prescale");
    apb_rd(8'h08, 32'h0000_0080, 32'hFFFF_FFFF, 1'b0, "rst_duty");
    apb_rd(8'h0C, 32'h0000_0031, 32'hFFFF_FFFF, 1'b0, "rst_blink_half");
    apb_rd(8'h10, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "rst_status");

    // Register write/readback, unused bits ignored.
    apb_wr(8'h04, 32'hABCD_1234, 4'hF, 1'b0, "wr_prescale");
    apb_rd(8'h04, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0, "rd_prescale");
    apb_wr(8'h00, 32'hFFFF_FFF8, 4'hF, 1'b0, "wr_ctrl_unused");
    apb_rd(8'h00, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "rd_ctrl_unused");
    apb_wr(8'h0C, 32'h0001_0007, 4'hF, 1'b0, "wr_blink_half");
    apb_rd(8'h0C, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0, "rd_blink_half");

    // Error responses leave state untouched.
    apb_rd(8'h14, 32'h0000_0000, 32'h0000_0000, 1'b1, "err_rd_0x14");
    apb_wr(8'h10, 32'h0000_FFFF, 4'hF, 1'b1, "err_wr_status");
    apb_wr(8'h02, 32'h0000_0007, 4'hF, 1'b1, "err_wr_0x02");
    apb_rd(8'h00, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "err_ctrl_kept");
    apb_rd(8'h0C, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0, "err_blink_kept");
    apb_rd(8'h10, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "err_status_kept");

    // Byte strobes on DUTY.
    apb_wr(8'h08, 32'h0000_0080, 4'hF, 1'b0, "wr_duty_80");
    apb_wr(8'h08, 32'h0000_00FF, 4'b0010, 1'b0, "wr_duty_strb");
    apb_rd(8'h08, STRB_DUTY_EXP, 32'hFFFF_FFFF, 1'b0, "rd_duty_strb");

    // PWM: PRESCALE=0, DUTY=64 -> led high after edge m iff (m-1)%256 < 64.
    apb_wr(8'h04, 32'h0000_0000, 4'hF, 1'b0, "pwm_prescale");
    apb_wr(8'h08, 32'h0000_0040, 4'hF, 1'b0, "pwm_duty");
    apb_wr(8'h00, 32'h0000_0001, 4'hF, 1'b0, "pwm_ctrl");
    for (int m = 1; m <= 520; m++) begin
      @(posedge pclk); #1;
      do_probe({2'b10, (((m - 1) % 256) < 64) ? 1'b1 : 1'b0}, $sformatf("pwm_led[%0d]", m));
    end
    // Status read lands after edge 522: cnt=10, led=1, phase=0.
    apb_rd(8'h10, 32'h0000_0A01, 32'hFFFF_FFFF, 1'b0, "pwm_status");

    // Blink: DUTY=255, BLINK_HALF=1 -> phase toggles every 512 cycles.
    apb_wr(8'h00, 32'h0000_0000, 4'hF, 1'b0, "blink_stop");
    apb_wr(8'h08, 32'h0000_00FF, 4'hF, 1'b0, "blink_duty");
    apb_wr(8'h0C, 32'h0000_0001, 4'hF, 1'b0, "blink_half");
    apb_wr(8'h00, 32'h0000_0003, 4'hF, 1'b0, "blink_ctrl");
    for (int m = 1; m <= 1100; m++) begin
      @(posedge pclk); #1;
      do_probe({2'b10, ((((m - 1) % 256) != 255) && ((((m - 1) / 512) % 2) == 1)) ? 1'b1 : 1'b0},
               $sformatf("blink_led[%0d]", m));
    end
    // Status after edge 1102: cnt=78, phase=0, led=0.
    apb_rd(8'h10, 32'h0000_4E00, 32'hFFFF_FFFF, 1'b0, "blink_status");

    // Disable with invert: CTRL=5 mid-period, then CTRL=4.
    apb_wr(8'h04, 32'h0000_0003, 4'hF, 1'b0, "inv_prescale");
    apb_wr(8'h08, 32'h0000_0080, 4'hF, 1'b0, "inv_duty");
    apb_wr(8'h00, 32'h0000_0005, 4'hF, 1'b0, "inv_ctrl5");
    repeat (37) @(posedge pclk);
    apb_wr(8'h00, 32'h0000_0004, 4'hF, 1'b0, "inv_ctrl4");
    @(posedge pclk); #1;
    do_probe(3'b101, "inv_led");
    apb_rd(8'h10, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, "inv_status");
    apb_rd(8'h00, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0, "inv_ctrl");

    // Second reset with psel idle: handshake stays 1/0, defaults return.
    @(posedge pclk); #1;
    prst = 1'b1;
    @(posedge pclk); #1;
    do_probe(3'b100, "rst2_idle_a");
    @(posedge pclk); #1;
    prst = 1'b0;
    do_probe(3'b100, "rst2_idle_b");
    apb_rd(8'h00, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "rst2_ctrl");
    apb_rd(8'h04, 32'h0000_010D, 32'hFFFF_FFFF, 1'b0, "rst2_prescale");
    apb_rd(8'h08, 32'h0000_0080, 32'hFFFF_FFFF, 1'b0, "rst2_duty");
    apb_rd(8'h0C, 32'h0000_0031, 32'hFFFF_FFFF, 1'b0, "rst2_blink_half");
    apb_rd(8'h10, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "rst2_status");

    repeat (2) @(posedge pclk);
    checks++;
    if ((exp_data_q.size() != 0) || (probe_q.size() != 0)) begin
      errors++;
      $display("FAIL drain: got %0d apb / %0d probe entries left, expected 0 / 0",
               exp_data_q.size(), probe_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb2_pwm_led.md
APB2_PWM_LED -- requirements
Module: apb2_pwm_led

Interface
REQ-001 SHALL have parameter RST_PRESCALE, default 16'd269, meaning the prescaler reload value after reset.
REQ-002 SHALL have parameter RST_DUTY, default 8'd128, meaning the duty value after reset.
REQ-003 SHALL have port pclk, input, 1: the single clock, shared with the APB master.
REQ-004 SHALL have port prst, input, 1: reset; synchronous and active-high.
REQ-005 SHALL have APB2 inputs: psel 1, penable 1, pwrite 1, paddr 8, pwdata 32, pstrb 4, pprot 3 (pprot ignored).
REQ-006 SHALL have APB2 outputs: prdata 32, pready 1, pslverr 1.
REQ-007 SHALL have port led_o, output, 1: registered PWM/blink LED drive.

Function
REQ-008 SHALL decode paddr[7:2] to these registers:
- 0x00 CTRL [2:0]: bit0 EN, bit1 BLINK_EN, bit2 INV.
- 0x04 PRESCALE [15:0].
- 0x08 DUTY [7:0].
- 0x0C BLINK_HALF [15:0].
- 0x10 STATUS, read-only: bit0 led_o, bit1 blink phase, bits[15:8] PWM counter.
REQ-009 SHALL drive pready high during every access phase (zero wait states).
REQ-010 SHALL assert pslverr with pready, in the access phase only, for paddr >= 0x14, for paddr[1:0] != 0, and for writes to STATUS; such writes change no state.
REQ-011 SHALL commit writes in the cycle with psel & penable & pwrite; unused bits are ignored.
REQ-012 SHALL return read data on prdata combinationally during psel & ~pwrite, with unused bits zero; prdata SHALL be 0 otherwise.
REQ-013 SHALL implement a 16-bit prescaler counting 0..PRESCALE, with tick = 1 for one cycle when the count equals PRESCALE, then wrap to 0; PRESCALE=0 SHALL tick every cycle.
REQ-014 SHALL clear the prescaler count in the cycle a PRESCALE write commits.
REQ-015 SHALL increment an 8-bit PWM counter on each tick, wrapping 255->0; the wrap tick SHALL be wrap = tick & (cnt==255).
REQ-016 SHALL use pwm = (cnt < DUTY); DUTY=0 gives always 0, DUTY=255 gives 255/256 high.
REQ-017 SHALL implement a 16-bit blink counter advancing on wrap; when it reaches BLINK_HALF it SHALL clear and toggle phase; BLINK_HALF=0 SHALL toggle on every wrap.
REQ-018 SHALL register led_o <= INV ^ (EN & pwm & (~BLINK_EN | phase)), one cycle after its inputs.
REQ-019 SHALL hold the prescaler, PWM counter, blink counter and phase at 0 while EN=0; led_o SHALL then equal INV.
REQ-020 SHALL, when a DUTY write and a tick coincide, apply the new DUTY from the next cycle's comparison; the counters SHALL be unaffected.

Reset
REQ-021 SHALL, while prst=1 at a pclk edge, load the following values, overriding any coincident APB write:
- CTRL=0, PRESCALE=RST_PRESCALE, DUTY=RST_DUTY, BLINK_HALF=16'd49.
- All counters 0, phase 0, led_o 0.
REQ-022 SHALL hold pready=1 and pslverr=0 when psel=0, including during reset.

Configuration
REQ-023 SHALL honour pstrb per byte lane on writes when macro APB2_PWM_LED_PSTRB_EN is defined; a lane with strobe 0 SHALL keep its old bits.
REQ-024 SHALL, without APB2_PWM_LED_PSTRB_EN, ignore pstrb and write all implemented bits.

Verification
REQ-025 SHALL cover reset: prst high for 2 cycles, with a concurrent CTRL write of 1 -> CTRL=0, led_o=0, PRESCALE reads 269, DUTY reads 128.
REQ-026 SHALL cover PWM duty: PRESCALE=0, DUTY=64, CTRL=1 -> led_o high 64 of every 256 cycles, rising 1 cycle after cnt==0.
REQ-027 SHALL cover blink: PRESCALE=0, DUTY=255, BLINK_HALF=1, CTRL=3 -> phase toggles every 512 cycles; led_o low throughout each phase-0 window.
REQ-028 SHALL cover error responses: read 0x14, write 0x10, write 0x02 -> pslverr=1 with pready=1 in each access phase; registers unchanged.
REQ-029 SHALL cover strobes: DUTY=0x80, then write 0x0000_00FF to DUTY with pstrb=4'b0010 -> DUTY reads 0x80 with the macro, 0xFF without.
REQ-030 SHALL cover disable and invert: CTRL=5 mid-period, then CTRL=4 -> counters read 0 and led_o=1 one cycle after the CTRL=4 write.
